// File: rtl/frame_proc_sequencer.sv
// frame_proc_sequencer: sequences the capture buffer and the image-processing core.
// On a request it waits for a clean full frame, freezes capture writes, hands
// the frame buffer read port to the processing core, starts it, and latches
// the color/figure result. Afterwards it returns the buffer to live capture
// and VGA display.
// Optional feature: define PROC_TIMEOUT_EN to build the processing watchdog
// (24-bit counter, limit TIMEOUT_CYCLES); otherwise error is tied to 0.
module frame_proc_sequencer #(
  parameter int AW             = 15,
  parameter int FRAMES_TO_SKIP = 1,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_procesamiento,
  input  logic          cap_frame_start,
  input  logic          cap_frame_end,
  output logic          cap_we_en,
  input  logic [AW-1:0] vga_addr,
  input  logic [AW-1:0] proc_addr,
  output logic [AW-1:0] buf_rd_addr,
  output logic          buf_sel,
  output logic          vga_blank,
  output logic          proc_start,
  input  logic          proc_done,
  input  logic [1:0]    proc_color,
  input  logic [1:0]    proc_figure,
  output logic [1:0]    color,
  output logic [1:0]    figure,
  output logic          done,
  output logic          busy,
  output logic          error
);

  typedef enum logic [2:0] {
    S_FREE, S_ARM, S_GRAB, S_FREEZE, S_PROC, S_REPORT
  } state_t;

  localparam logic [3:0] SKIP_LIMIT = 4'(FRAMES_TO_SKIP);

  state_t     state_q, state_d;
  logic [3:0] skip_q, skip_d;
  logic       init_prev_q, init_prev_d;
  logic       cap_we_en_q, cap_we_en_d;
  logic       buf_sel_q, buf_sel_d;
  logic       proc_start_q, proc_start_d;
  logic [1:0] color_q, color_d;
  logic [1:0] figure_q, figure_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       req;

`ifdef PROC_TIMEOUT_EN
  localparam logic [23:0] TIMEOUT_LIMIT = 24'(TIMEOUT_CYCLES);
  logic [23:0] wdog_q, wdog_d;
  logic        error_q, error_d;
`endif

  // Rising edge of the request; init_prev resets high so a level held
  // through reset is not mistaken for a new request.
  assign req = init_procesamiento & ~init_prev_q;

  // Read-port mux: zero-latency, steered by the registered owner flag.
  assign buf_rd_addr = buf_sel_q ? proc_addr : vga_addr;

  // Next-state, result latching and registered-output decode.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned (no latches).
    state_d     = state_q;
    skip_d      = skip_q;
    init_prev_d = init_procesamiento;
    color_d     = color_q;
    figure_d    = figure_q;
    done_d      = done_q;
`ifdef PROC_TIMEOUT_EN
    error_d     = error_q;
    wdog_d      = '0;
`endif

    case (state_q)
      S_FREE: begin
        if (req) begin
          state_d = S_ARM;
          skip_d  = '0;
          done_d  = 1'b0;
`ifdef PROC_TIMEOUT_EN
          error_d = 1'b0;
`endif
        end
      end
      // Frame-end is ignored here: only frame starts are counted.
      S_ARM: begin
        if (cap_frame_start) begin
          if (skip_q == SKIP_LIMIT) state_d = S_GRAB;
          else                      skip_d  = skip_q + 4'd1;
        end
      end
      S_GRAB: begin
        if (cap_frame_end) state_d = S_FREEZE;
      end
      S_FREEZE: state_d = S_PROC;
      // proc_start_q is high only in the entry cycle, so a completion pulse
      // coinciding with the start is ignored.
      S_PROC: begin
        if (!proc_start_q && proc_done) begin
          color_d  = proc_color;
          figure_d = proc_figure;
          done_d   = 1'b1;
          state_d  = S_REPORT;
        end
`ifdef PROC_TIMEOUT_EN
        else if (wdog_q >= TIMEOUT_LIMIT) begin
          color_d  = 2'b00;
          figure_d = 2'b00;
          done_d   = 1'b1;
          error_d  = 1'b1;
          state_d  = S_REPORT;
        end else begin
          wdog_d = wdog_q + 24'd1;
        end
`endif
      end
      S_REPORT: state_d = S_FREE;
      default:  state_d = S_FREE;
    endcase

    // Outputs are decoded from the next state so they change together with it.
    cap_we_en_d  = !(state_d inside {S_FREEZE, S_PROC, S_REPORT});
    buf_sel_d    = !cap_we_en_d;
    busy_d       = (state_d != S_FREE);
    proc_start_d = (state_d == S_PROC) && (state_q == S_FREEZE);
  end

  // State and output registers; reset abandons any in-flight sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FREE;
      skip_q       <= '0;
      init_prev_q  <= 1'b1;
      cap_we_en_q  <= 1'b1;
      buf_sel_q    <= 1'b0;
      proc_start_q <= 1'b0;
      color_q      <= '0;
      figure_q     <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      skip_q       <= skip_d;
      init_prev_q  <= init_prev_d;
      cap_we_en_q  <= cap_we_en_d;
      buf_sel_q    <= buf_sel_d;
      proc_start_q <= proc_start_d;
      color_q      <= color_d;
      figure_q     <= figure_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

`ifdef PROC_TIMEOUT_EN
  // Watchdog counter and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q  <= '0;
      error_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      error_q <= error_d;
    end
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign cap_we_en  = cap_we_en_q;
  assign buf_sel    = buf_sel_q;
  assign vga_blank  = buf_sel_q;
  assign proc_start = proc_start_q;
  assign color      = color_q;
  assign figure     = figure_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_frame_proc_sequencer.sv
// Testbench for frame_proc_sequencer: scenario tasks with a result scoreboard.
module tb_frame_proc_sequencer;

  localparam int AW = 15;

  typedef struct packed {
    logic [1:0] color;
    logic [1:0] figure;
    logic       error;
  } res_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_procesamiento = 1'b0;
  logic          cap_frame_start = 1'b0;
  logic          cap_frame_end = 1'b0;
  logic          cap_we_en;
  logic [AW-1:0] vga_addr = 15'h1234;
  logic [AW-1:0] proc_addr = 15'h0042;
  logic [AW-1:0] buf_rd_addr;
  logic          buf_sel;
  logic          vga_blank;
  logic          proc_start;
  logic          proc_done = 1'b0;
  logic [1:0]    proc_color = 2'b00;
  logic [1:0]    proc_figure = 2'b00;
  logic [1:0]    color;
  logic [1:0]    figure;
  logic          done;
  logic          busy;
  logic          error;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   ps_count = 0;
  res_t exp_q[$];
  res_t exp_r;
  res_t act_r;

  frame_proc_sequencer #(
    .AW(AW), .FRAMES_TO_SKIP(1), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst), .init_procesamiento(init_procesamiento),
    .cap_frame_start(cap_frame_start), .cap_frame_end(cap_frame_end),
    .cap_we_en(cap_we_en), .vga_addr(vga_addr), .proc_addr(proc_addr),
    .buf_rd_addr(buf_rd_addr), .buf_sel(buf_sel), .vga_blank(vga_blank),
    .proc_start(proc_start), .proc_done(proc_done), .proc_color(proc_color),
    .proc_figure(proc_figure), .color(color), .figure(figure), .done(done),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Count start pulses away from the active edge.
  always @(negedge clk) if (rst && proc_start) ps_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    cap_frame_start = 1'b1; tick(); cap_frame_start = 1'b0;
  endtask

  task automatic pulse_end();
    cap_frame_end = 1'b1; tick(); cap_frame_end = 1'b0;
  endtask

  // Request, skip one frame, capture the next; returns in the PROC entry cycle.
  task automatic run_to_proc();
    init_procesamiento = 1'b1; tick(); init_procesamiento = 1'b0;
    pulse_start();
    pulse_start();
    pulse_end();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    init_procesamiento = 1'b1;
    #2 rst = 1'b0;
    #1;
    tests_run++; if (cap_we_en !== 1'b1) begin tests_failed++; $display("FAIL reset_we got=%b exp=1", cap_we_en); end
    tests_run++; if (buf_sel !== 1'b0) begin tests_failed++; $display("FAIL reset_sel got=%b exp=0", buf_sel); end
    tests_run++; if ({proc_start, done, busy, error, color, figure} !== 8'h00) begin tests_failed++;
      $display("FAIL reset_outs got=%b exp=00000000", {proc_start, done, busy, error, color, figure}); end
    tick(); tick();
    rst = 1'b1;
    repeat (200) tick();
    tests_run++; if (ps_count !== 0) begin tests_failed++; $display("FAIL held_init_start got=%0d exp=0", ps_count); end
    tests_run++; if ({busy, cap_we_en, buf_sel} !== 3'b010) begin tests_failed++;
      $display("FAIL held_init_idle got=%b exp=010", {busy, cap_we_en, buf_sel}); end
    init_procesamiento = 1'b0;
    tick();
  endtask

  task automatic test_capture();
    init_procesamiento = 1'b1; tick(); init_procesamiento = 1'b0;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL arm_busy got=%b exp=1", busy); end
    tests_run++; if (buf_rd_addr !== 15'h1234) begin tests_failed++; $display("FAIL arm_addr got=%h exp=1234", buf_rd_addr); end
    pulse_start();
    pulse_end();
    tests_run++; if (cap_we_en !== 1'b1) begin tests_failed++; $display("FAIL arm_end_ignored got=%b exp=1", cap_we_en); end
    pulse_start();
    tick(); tick();
    tests_run++; if ({cap_we_en, buf_rd_addr} !== {1'b1, 15'h1234}) begin tests_failed++;
      $display("FAIL grab_live got=%b/%h exp=1/1234", cap_we_en, buf_rd_addr); end
    pulse_end();  // cycle N sampled; now at N+1
    tests_run++; if ({cap_we_en, buf_sel, vga_blank, proc_start} !== 4'b0110) begin tests_failed++;
      $display("FAIL freeze got=%b exp=0110", {cap_we_en, buf_sel, vga_blank, proc_start}); end
    tests_run++; if (buf_rd_addr !== 15'h0042) begin tests_failed++; $display("FAIL freeze_addr got=%h exp=0042", buf_rd_addr); end
    tick();  // N+2: PROC entry
    tests_run++; if (proc_start !== 1'b1) begin tests_failed++; $display("FAIL proc_start got=%b exp=1", proc_start); end
    proc_done = 1'b1; proc_color = 2'b11; proc_figure = 2'b11;  // entry-cycle done is ignored
    tick();
    proc_done = 1'b0;
    tests_run++; if ({proc_start, done, busy} !== 3'b001) begin tests_failed++;
      $display("FAIL entry_done_ignored got=%b exp=001", {proc_start, done, busy}); end
    repeat (5) tick();
    tests_run++; if ({done, buf_rd_addr} !== {1'b0, 15'h0042}) begin tests_failed++;
      $display("FAIL proc_wait got=%b/%h exp=0/0042", done, buf_rd_addr); end
    exp_q.push_back('{color: 2'b10, figure: 2'b01, error: 1'b0});
    proc_done = 1'b1; proc_color = 2'b10; proc_figure = 2'b01;
    tick();  // M+1
    proc_done = 1'b0; proc_color = 2'b11; proc_figure = 2'b11;
    act_r = '{color: color, figure: figure, error: error};
    tests_run++;
    if (exp_q.size() == 0) begin tests_failed++; $display("FAIL capture_sb got=empty exp=entry"); end
    else begin
      exp_r = exp_q.pop_front();
      if ({done, act_r} !== {1'b1, exp_r}) begin tests_failed++;
        $display("FAIL capture_result got=%b/%b exp=1/%b", done, act_r, exp_r); end
    end
    tests_run++; if ({cap_we_en, buf_sel} !== 2'b01) begin tests_failed++; $display("FAIL report_hold got=%b exp=01", {cap_we_en, buf_sel}); end
    tick();  // M+2
    tests_run++; if ({cap_we_en, buf_sel, busy, buf_rd_addr} !== {3'b100, 15'h1234}) begin tests_failed++;
      $display("FAIL release got=%b/%h exp=100/1234", {cap_we_en, buf_sel, busy}, buf_rd_addr); end
    repeat (5) tick();
    tests_run++; if ({done, color, figure} !== 5'b11001) begin tests_failed++;
      $display("FAIL result_held got=%b exp=11001", {done, color, figure}); end
    tests_run++; if (ps_count !== 1) begin tests_failed++; $display("FAIL capture_starts got=%0d exp=1", ps_count); end
  endtask

  task automatic test_back_to_back();
    int base = ps_count;
    run_to_proc();
    tick();
    init_procesamiento = 1'b1; tick(); init_procesamiento = 1'b0;
    pulse_start();
    pulse_end();
    tests_run++; if ({busy, buf_sel, cap_we_en, done} !== 4'b1100) begin tests_failed++;
      $display("FAIL dropped_req_proc got=%b exp=1100", {busy, buf_sel, cap_we_en, done}); end
    exp_q.push_back('{color: 2'b01, figure: 2'b10, error: 1'b0});
    proc_done = 1'b1; proc_color = 2'b01; proc_figure = 2'b10;
    tick();
    proc_done = 1'b0;
    init_procesamiento = 1'b1;  // edge seen in REPORT: dropped
    act_r = '{color: color, figure: figure, error: error};
    tests_run++;
    if (exp_q.size() == 0) begin tests_failed++; $display("FAIL b2b_sb got=empty exp=entry"); end
    else begin
      exp_r = exp_q.pop_front();
      if ({done, act_r} !== {1'b1, exp_r}) begin tests_failed++;
        $display("FAIL b2b_result got=%b/%b exp=1/%b", done, act_r, exp_r); end
    end
    tick();
    init_procesamiento = 1'b0;
    repeat (3) tick();
    tests_run++; if ({done, busy} !== 2'b10) begin tests_failed++; $display("FAIL report_req_dropped got=%b exp=10", {done, busy}); end
    tests_run++; if (ps_count - base !== 1) begin tests_failed++; $display("FAIL b2b_starts got=%0d exp=1", ps_count - base); end
  endtask

  task automatic test_timeout();
    run_to_proc();  // entry cycle E
`ifdef PROC_TIMEOUT_EN
    exp_q.push_back('{color: 2'b00, figure: 2'b00, error: 1'b1});
    repeat (100) tick();
    tests_run++; if ({done, busy} !== 2'b01) begin tests_failed++; $display("FAIL timeout_early got=%b exp=01", {done, busy}); end
    tick();  // E+101
    act_r = '{color: color, figure: figure, error: error};
    tests_run++;
    if (exp_q.size() == 0) begin tests_failed++; $display("FAIL timeout_sb got=empty exp=entry"); end
    else begin
      exp_r = exp_q.pop_front();
      if ({done, act_r} !== {1'b1, exp_r}) begin tests_failed++;
        $display("FAIL timeout_result got=%b/%b exp=1/%b", done, act_r, exp_r); end
    end
    tick(); tick();
    init_procesamiento = 1'b1; tick(); init_procesamiento = 1'b0;
    tests_run++; if ({error, done, busy} !== 3'b001) begin tests_failed++;
      $display("FAIL timeout_clear got=%b exp=001", {error, done, busy}); end
    rst = 1'b0; tick(); rst = 1'b1; tick();
`else
    repeat (150) tick();
    tests_run++; if ({busy, done, error} !== 3'b100) begin tests_failed++;
      $display("FAIL no_watchdog got=%b exp=100", {busy, done, error}); end
    exp_q.push_back('{color: 2'b11, figure: 2'b00, error: 1'b0});
    proc_done = 1'b1; proc_color = 2'b11; proc_figure = 2'b00;
    tick();
    proc_done = 1'b0;
    act_r = '{color: color, figure: figure, error: error};
    tests_run++;
    if (exp_q.size() == 0) begin tests_failed++; $display("FAIL late_done_sb got=empty exp=entry"); end
    else begin
      exp_r = exp_q.pop_front();
      if ({done, act_r} !== {1'b1, exp_r}) begin tests_failed++;
        $display("FAIL late_done_result got=%b/%b exp=1/%b", done, act_r, exp_r); end
    end
    tick();
`endif
  endtask

  task automatic test_reset_mid();
    int base;
    run_to_proc();
    repeat (3) tick();
    base = ps_count;
    #2 rst = 1'b0;
    #1;
    tests_run++; if ({cap_we_en, buf_sel, done, busy} !== 4'b1000) begin tests_failed++;
      $display("FAIL mid_reset got=%b exp=1000", {cap_we_en, buf_sel, done, busy}); end
    tick();
    rst = 1'b1;
    proc_done = 1'b1; proc_color = 2'b10; proc_figure = 2'b10;
    tick();
    proc_done = 1'b0;
    tick();
    tests_run++; if ({done, busy, cap_we_en, buf_sel} !== 4'b0010) begin tests_failed++;
      $display("FAIL late_done_ignored got=%b exp=0010", {done, busy, cap_we_en, buf_sel}); end
    tests_run++; if (ps_count !== base) begin tests_failed++; $display("FAIL mid_reset_starts got=%0d exp=%0d", ps_count, base); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    tests_run++; if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Run-time bound: the bench must never hang.
  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit expired");
  end

endmodule
